// File: rtl/collision_pkg.sv
// Shared types and sizing helper for the square collision detector.
package collision_pkg;

  typedef enum logic [1:0] {WAIT_START, SCAN, REPORT} coll_state_t;

  // Counter width able to hold every pixel of an inclusive (WIDTH+1)x(HEIGHT+1) window.
  function automatic int cnt_w(input int width, input int height);
    return $clog2((width + 1) * (height + 1) + 1);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing counters, syncs, blanking and colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vblnk_edge.sv
// Edge detector against the registered previous level; fall/rise are one-cycle pulses.
module vblnk_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic fall,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign fall = ~level & level_q;
  assign rise = level & ~level_q;

endmodule

// File: rtl/square_collision_detect.sv
// Counts target-coloured visible pixels inside the square's window each frame and
// reports the result at frame end through a sticky valid / ack handshake.
module square_collision_detect
  import collision_pkg::*;
#(
  parameter int          HEIGHT       = 8,
  parameter int          WIDTH        = 8,
  parameter logic [11:0] TARGET_COLOR = 12'h0_0_0,
  parameter int          HIT_MIN      = 1,
  parameter int          CNT_W        = cnt_w(WIDTH, HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  vga_if.in                vga_in,
  input  logic [11:0]      xpos_square,
  input  logic [11:0]      ypos_square,
  input  logic             hit_ack,
  output logic             frame_done,
  output logic             hit_valid,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             overrun
);

  localparam logic [12:0]      WIDTH13   = 13'(WIDTH);
  localparam logic [12:0]      HEIGHT13  = 13'(HEIGHT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HIT_MIN_C = CNT_W'(HIT_MIN);

  coll_state_t      state;
  coll_state_t      state_nxt;
  logic [11:0]      x_q;
  logic [11:0]      y_q;
  logic [CNT_W-1:0] cnt;
  logic             frame_start;
  logic             frame_end;
  logic             capture;
  logic             count_en;
  logic             report;
  logic             in_win;
  logic             pix_hit;
  logic [12:0]      hc13;
  logic [12:0]      vc13;
  logic [12:0]      x_lo;
  logic [12:0]      x_hi;
  logic [12:0]      y_lo;
  logic [12:0]      y_hi;

  vblnk_edge u_vblnk_edge (
    .clk   (clk),
    .rst   (rst),
    .level (vga_in.vblnk),
    .fall  (frame_start),
    .rise  (frame_end)
  );

  // 13-bit bounds so the far edge of a window near 4095 cannot wrap.
  assign hc13 = {2'b00, vga_in.hcount};
  assign vc13 = {2'b00, vga_in.vcount};
  assign x_lo = {1'b0, x_q};
  assign y_lo = {1'b0, y_q};
  assign x_hi = x_lo + WIDTH13;
  assign y_hi = y_lo + HEIGHT13;

  assign in_win  = (hc13 >= x_lo) && (hc13 <= x_hi) && (vc13 >= y_lo) && (vc13 <= y_hi);
  assign pix_hit = ~vga_in.hblnk && ~vga_in.vblnk && in_win && (vga_in.rgb == TARGET_COLOR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_START;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_START: if (frame_start) state_nxt = SCAN;
      SCAN:       if (frame_end)   state_nxt = REPORT;
      REPORT:     state_nxt = WAIT_START;
      default:    state_nxt = WAIT_START;
    endcase
  end

  always_comb begin
    capture  = (state == WAIT_START) && frame_start;
    count_en = (state == SCAN) && pix_hit;
    report   = (state == REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      cnt <= '0;
    end else if (capture) begin
      x_q <= xpos_square;
      y_q <= ypos_square;
      cnt <= '0;
    end else if (count_en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A report that meets an unacknowledged result flags overrun unless the ack lands now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      hit_valid  <= 1'b0;
      hit        <= 1'b0;
      hit_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= report;
      if (report) begin
        hit_count <= cnt;
        hit       <= (cnt >= HIT_MIN_C);
        hit_valid <= 1'b1;
        overrun   <= hit_valid & ~hit_ack;
      end else if (hit_ack && hit_valid) begin
        hit_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule
